// File: rtl/my_pkg.sv
// Shared core definitions: fetch-stage constants, tag width and fetch FSM encoding.
package my_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned TAG_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } fetch_state;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding, and
// feeds the decoder with tagged instructions, bubbles on hold and on redirect.
module fetch_unit
  import my_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             hold,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic [31:0]      instruction,
  output logic [31:0]      NPC_out,
  output logic [TAG_W-1:0] tag_out
);

  fetch_state       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      buf_instr_q, buf_instr_d;
  logic [31:0]      buf_pc_q, buf_pc_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      npc_q, npc_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  logic [31:0]      jt;
  logic [31:0]      pc_inc;
  logic [TAG_W-1:0] tag_inc;

  assign jt      = jump_target & ~32'h3;
  assign pc_inc  = pc_q + 32'd4;
  assign tag_inc = tag_q + TAG_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tag_d       = tag_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    tgt_d       = tgt_q;
    // Bubble by default: only the instruction changes, address and tag hold.
    instr_d     = NOP_INSTR;
    npc_d       = npc_q;
    tag_out_d   = tag_out_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (jump) begin
          pc_d  = jt;
          tag_d = tag_inc;
        end
      end

      S_FETCH: begin
        if (jump) begin
          tag_d = tag_inc;
          if (imem_ack) begin
            pc_d = jt;
          end else begin
            tgt_d   = jt;
            state_d = S_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (hold) begin
            buf_instr_d = imem_data;
            buf_pc_d    = pc_q;
            state_d     = S_HOLD;
          end else begin
            instr_d   = imem_data;
            npc_d     = pc_q;
            tag_out_d = tag_q;
          end
        end
      end

      S_HOLD: begin
        if (jump) begin
          tag_d   = tag_inc;
          pc_d    = jt;
          state_d = S_FETCH;
        end else if (!hold) begin
          instr_d   = buf_instr_q;
          npc_d     = buf_pc_q;
          tag_out_d = tag_q;
          state_d   = S_FETCH;
        end
      end

      S_DRAIN: begin
        // The stale request stays up until acked; its data is always dropped.
        if (jump) begin
          tag_d = tag_inc;
          if (imem_ack) begin
            pc_d    = jt;
            state_d = S_FETCH;
          end else begin
            tgt_d = jt;
          end
        end else if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      tag_q       <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      tgt_q       <= '0;
      instr_q     <= NOP_INSTR;
      npc_q       <= '0;
      tag_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tag_q       <= tag_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      tgt_q       <= tgt_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
      tag_out_q   <= tag_out_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign NPC_out     = npc_q;
  assign tag_out     = tag_out_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core: it owns the program counter, issues single-outstanding requests to instruction memory, and presents each fetched word with its address and 4-bit tag to the decoder. It produces the decoder's `instruction`, `NPC_IN` and `tag_in` inputs. It takes redirects from the branch unit, and each redirect bumps the tag so downstream units can kill wrong-path instructions. It also takes a backend hold and inserts NOP bubbles while the hold is asserted.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock; dominates all other inputs.
- jump  in  1  single-cycle redirect strobe from branch unit.
- jump_target  in  32  new PC, sampled when jump=1; bits [1:0] forced to 0.
- hold  in  1  backend stall; no real instruction is issued to outputs while high.
- imem_req  out  1  request to instruction memory; held high until imem_ack.
- imem_addr  out  32  word address of outstanding request; stable while imem_req=1.
- imem_ack  in  1  response strobe; imem_data valid this cycle; may coincide with first cycle of imem_req.
- imem_data  in  32  fetched word.
- instruction  out  32  registered instruction to decoder.
- NPC_out  out  32  registered address of `instruction`.
- tag_out  out  4  registered tag of `instruction`.

## Operation
- Registers: pc (address of current or next request), tag (4 bits), buf_instr/buf_pc (one-entry skid), tgt (saved redirect target), state.
- States: S_IDLE, S_FETCH, S_HOLD, S_DRAIN.
- imem_req=1 in S_FETCH and S_DRAIN only. imem_addr=pc in all states.
- Bubble: instruction=NOP_INSTR (32'h0000_0013), NPC_out and tag_out unchanged.
- Priority each cycle: reset > jump > ack/hold.
- S_IDLE: outputs load a bubble; next state is S_FETCH.
- S_FETCH, ack=1, hold=0, jump=0: outputs load {imem_data, pc, tag}; pc<=pc+4; stay in S_FETCH.
- S_FETCH, ack=1, hold=1, jump=0: buf<={imem_data, pc}; pc<=pc+4; outputs load a bubble; go to S_HOLD.
- S_FETCH, ack=0: outputs load a bubble; stay in S_FETCH. A request is never retracted.
- S_HOLD, hold=1: outputs load a bubble; no request is issued.
- S_HOLD, hold=0: outputs load {buf_instr, buf_pc, tag}; go to S_FETCH.
- Redirect (jump=1), any state except S_IDLE:
  - tag<=tag+1, wrapping 15->0; outputs load a bubble.
  - If a request is outstanding and ack=0 (S_FETCH or S_DRAIN): tgt<=jump_target; go to S_DRAIN.
  - Otherwise: pc<=jump_target; go to S_FETCH. This covers ack=1 in the same cycle (data discarded) and S_HOLD (buffer discarded).
- S_DRAIN: keeps the old request up. On ack: data discarded, pc<=tgt, go to S_FETCH. A further jump in S_DRAIN overwrites tgt and bumps tag again.
- jump in S_IDLE: pc<=jump_target, tag+1, then S_FETCH.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0); tag is modulo 16.

## Timing
- Reset values: pc=RESET_PC, tag=0, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, instruction=32'h0000_0013, NPC_out=0, tag_out=0, buf=0, tgt=0.
- First request: imem_req rises in the second cycle after reset deasserts.
- Latency: an instruction appears on the outputs the cycle after its imem_ack.
- Throughput: one instruction per cycle with zero-wait memory (ack in every request cycle); otherwise one per ack.
- Redirect penalty with zero-wait memory: exactly one bubble cycle. The first new-target request is issued in the cycle after jump.
- Reset asserted mid-request: the request is abandoned and imem_req drops next cycle. Memory must tolerate a dropped request; a late ack seen in S_IDLE is ignored.

## Structure
- Add to my_pkg:
  - localparam NOP_INSTR = 32'h0000_0013.
  - typedef enum fetch_state {S_IDLE, S_FETCH, S_HOLD, S_DRAIN}.
- Tag width stays 4, matching decoder tag_in; define TAG_W=4 in my_pkg.
- Single module. The skid entry is small and stays inline; no sub-module.

## Test plan
- Reset, zero-wait memory, mem[0]=0x00500093, mem[4]=0x00A00113 -> outputs 0x00500093/NPC 0x0/tag 0, then 0x00A00113/NPC 0x4 on the following cycle; imem_addr sequence 0, 4, 8.
- Memory with 3-cycle ack latency -> imem_addr stable over each 3-cycle request, two bubbles between instructions, NPC values 0, 4, 8.
- hold=1 for 4 cycles asserted in the ack cycle of addr 0x8 -> 4+ bubbles, then instruction at 0x8 exactly once with NPC 0x8; no duplicate; next request is 0xC.
- jump (target 0x100) while a 2-cycle-latency request to 0x10 is outstanding -> S_DRAIN; 0x10 data never reaches outputs; next request 0x100; tag_out of the 0x100 instruction is 1.
- 16 consecutive jumps -> tag wraps 15->0; jump with target 0x203 -> fetch at 0x200; jump coincident with ack discards that ack's data.
- reset asserted during an outstanding request -> next cycle imem_req=0, instruction=0x13, tag_out=0, NPC_out=0; fetch restarts at RESET_PC.
